// File: rtl/pipe_stage.sv
// Elastic pipeline stage register: main entry plus a skid entry behind a valid/ready
// handshake, with synchronous flush and saturating stall/bubble counters.
module pipe_stage #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  // State is the pair {main_valid, skid_valid}; 2'b01 is unreachable.
  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] FULL  = 2'b10;
  localparam logic [1:0] SKID  = 2'b11;

  logic              main_valid_q, main_valid_d;
  logic              skid_valid_q, skid_valid_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              in_ready_q, in_ready_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

  logic       push_c;
  logic       pop_c;
  logic [1:0] state_c;

  assign push_c  = in_valid && in_ready_q;
  assign pop_c   = main_valid_q && out_ready;
  assign state_c = {main_valid_q, skid_valid_q};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_ctrl_q  <= '0;
      skid_ctrl_q  <= '0;
      main_data_q  <= '0;
      skid_data_q  <= '0;
      in_ready_q   <= 1'b1;
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_ctrl_q  <= main_ctrl_d;
      skid_ctrl_q  <= skid_ctrl_d;
      main_data_q  <= main_data_d;
      skid_data_q  <= skid_data_d;
      in_ready_q   <= in_ready_d;
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  // Next-state: flush wins over push; ctrl is zeroed whenever an entry goes empty.
  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_ctrl_d  = main_ctrl_q;
    skid_ctrl_d  = skid_ctrl_q;
    main_data_d  = main_data_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      main_ctrl_d  = '0;
      skid_ctrl_d  = '0;
    end else begin
      case (state_c)
        EMPTY: begin
          if (push_c) begin
            main_valid_d = 1'b1;
            main_ctrl_d  = in_ctrl;
            main_data_d  = in_data;
          end
        end
        FULL: begin
          if (push_c && pop_c) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end else if (push_c) begin
            skid_valid_d = 1'b1;
            skid_ctrl_d  = in_ctrl;
            skid_data_d  = in_data;
          end else if (pop_c) begin
            main_valid_d = 1'b0;
            main_ctrl_d  = '0;
          end
        end
        SKID: begin
          if (pop_c) begin
            main_ctrl_d  = skid_ctrl_q;
            main_data_d  = skid_data_q;
            skid_valid_d = 1'b0;
            skid_ctrl_d  = '0;
          end
        end
        default: begin
          main_valid_d = 1'b0;
          skid_valid_d = 1'b0;
          main_ctrl_d  = '0;
          skid_ctrl_d  = '0;
        end
      endcase
    end
    in_ready_d = !skid_valid_d;
  end

  // Saturating performance counters; flush leaves them alone.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (main_valid_q && !out_ready && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (!main_valid_q && out_ready && (bubble_cnt_q != '1))
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = main_valid_q;
  assign out_ctrl   = main_ctrl_q;
  assign out_data   = main_data_q;
  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_stage.sv
// Directed bench for pipe_stage; a second instance with 4-bit counters shares the
// stimulus so counter saturation can be observed.
module tb_pipe_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_ctrl;
  logic [63:0] in_data;
  logic        out_ready;
  logic        flush;
  logic        in_ready, out_valid;
  logic [7:0]  out_ctrl;
  logic [63:0] out_data;
  logic [15:0] stall_cnt, bubble_cnt;
  logic        s_in_ready, s_out_valid;
  logic [7:0]  s_out_ctrl;
  logic [63:0] s_out_data;
  logic [3:0]  s_stall_cnt, s_bubble_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .flush(flush), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  pipe_stage #(.CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(s_out_valid),
    .out_ready(out_ready), .out_ctrl(s_out_ctrl), .out_data(s_out_data),
    .flush(flush), .stall_cnt(s_stall_cnt), .bubble_cnt(s_bubble_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0;
    out_ready = 1'b0; flush = 1'b0;
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0;
    out_ready = 1'b0; flush = 1'b0;
    step(); step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (out_ctrl !== 8'h00) begin bad++; $display("FAIL reset_out_ctrl got=%h exp=00", out_ctrl); end
    total++; if (out_data !== 64'h0) begin bad++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL reset_stall got=%0d exp=0", stall_cnt); end
    total++; if (bubble_cnt !== 16'd0) begin bad++; $display("FAIL reset_bubble got=%0d exp=0", bubble_cnt); end
    rst = 1'b1;
  endtask

  task automatic test_stream();
    logic [63:0] vals [3];
    vals[0] = 64'h10; vals[1] = 64'h20; vals[2] = 64'h30;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = vals[i];
      in_ctrl = 8'(i + 1);
      step();
      total++; if (out_valid !== 1'b1 || out_data !== vals[i]) begin bad++; $display("FAIL stream_data%0d got=%b/%h exp=1/%h", i, out_valid, out_data, vals[i]); end
      total++; if (out_ctrl !== 8'(i + 1)) begin bad++; $display("FAIL stream_ctrl%0d got=%h exp=%h", i, out_ctrl, 8'(i + 1)); end
      // Only the idle cycle before the first push counts as a bubble.
      total++; if (bubble_cnt !== 16'd1) begin bad++; $display("FAIL stream_bubble%0d got=%0d exp=1", i, bubble_cnt); end
    end
    in_valid = 1'b0;
    step();
    total++; if (out_valid !== 1'b0 || out_ctrl !== 8'h00) begin bad++; $display("FAIL stream_drain got=%b/%h exp=0/00", out_valid, out_ctrl); end
    total++; if (out_data !== 64'h30) begin bad++; $display("FAIL stream_hold_data got=%h exp=30", out_data); end
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    in_valid = 1'b1; in_ctrl = 8'h11; in_data = 64'hA1;
    step();
    total++; if (in_ready !== 1'b1 || out_data !== 64'hA1) begin bad++; $display("FAIL bp_first got=%b/%h exp=1/a1", in_ready, out_data); end
    in_ctrl = 8'h22; in_data = 64'hB2;
    step();
    in_valid = 1'b0;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready_low got=%b exp=0", in_ready); end
    total++; if (out_data !== 64'hA1 || out_ctrl !== 8'h11) begin bad++; $display("FAIL bp_hold_a got=%h/%h exp=a1/11", out_data, out_ctrl); end
    total++; if (stall_cnt !== 16'd1) begin bad++; $display("FAIL bp_stall1 got=%0d exp=1", stall_cnt); end
    step();
    total++; if (stall_cnt !== 16'd2 || in_ready !== 1'b0) begin bad++; $display("FAIL bp_stall2 got=%0d/%b exp=2/0", stall_cnt, in_ready); end
    out_ready = 1'b1;
    step();
    total++; if (out_valid !== 1'b1 || out_data !== 64'hB2 || out_ctrl !== 8'h22) begin bad++; $display("FAIL bp_pop_b got=%b/%h/%h exp=1/b2/22", out_valid, out_data, out_ctrl); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_in_ready_high got=%b exp=1", in_ready); end
    step();
    total++; if (out_valid !== 1'b0 || out_ctrl !== 8'h00) begin bad++; $display("FAIL bp_empty got=%b/%h exp=0/00", out_valid, out_ctrl); end
    total++; if (stall_cnt !== 16'd2 || bubble_cnt !== 16'd1) begin bad++; $display("FAIL bp_counters got=%0d/%0d exp=2/1", stall_cnt, bubble_cnt); end
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    in_valid = 1'b1; in_ctrl = 8'hFF; in_data = 64'h55;
    step();
    in_data = 64'h66;
    step();
    total++; if (in_ready !== 1'b0 || out_ctrl !== 8'hFF) begin bad++; $display("FAIL flush_setup got=%b/%h exp=0/ff", in_ready, out_ctrl); end
    flush = 1'b1; in_valid = 1'b1; in_ctrl = 8'h77; in_data = 64'h99;
    step();
    flush = 1'b0; in_valid = 1'b0;
    total++; if (out_valid !== 1'b0 || out_ctrl !== 8'h00) begin bad++; $display("FAIL flush_empty got=%b/%h exp=0/00", out_valid, out_ctrl); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_in_ready got=%b exp=1", in_ready); end
    total++; if (stall_cnt !== 16'd4) begin bad++; $display("FAIL flush_stall got=%0d exp=4", stall_cnt); end
    out_ready = 1'b1;
    step();
    total++; if (out_valid !== 1'b0 || out_data !== 64'h55) begin bad++; $display("FAIL flush_no_99 got=%b/%h exp=0/55", out_valid, out_data); end
    total++; if (bubble_cnt !== 16'd2) begin bad++; $display("FAIL flush_bubble got=%0d exp=2", bubble_cnt); end
    out_ready = 1'b0;
  endtask

  task automatic test_bubble();
    do_reset();
    out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      total++; if (out_valid !== 1'b0 || out_ctrl !== 8'h00) begin bad++; $display("FAIL bubble_ctrl%0d got=%b/%h exp=0/00", i, out_valid, out_ctrl); end
      total++; if (bubble_cnt !== 16'(i)) begin bad++; $display("FAIL bubble_cnt%0d got=%0d exp=%0d", i, bubble_cnt, i); end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_saturation();
    do_reset();
    in_valid = 1'b1; in_ctrl = 8'h03; in_data = 64'h42;
    step();
    in_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 14 || k == 15 || k == 16 || k == 20) begin
        total++; if (s_stall_cnt !== 4'((k < 15) ? k : 15)) begin bad++; $display("FAIL sat_small%0d got=%0d exp=%0d", k, s_stall_cnt, (k < 15) ? k : 15); end
      end
    end
    total++; if (stall_cnt !== 16'd20) begin bad++; $display("FAIL sat_wide got=%0d exp=20", stall_cnt); end
    total++; if (s_bubble_cnt !== 4'd0) begin bad++; $display("FAIL sat_small_bubble got=%0d exp=0", s_bubble_cnt); end
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; in_ctrl = 8'h0C; in_data = 64'h77;
    step();
    in_valid = 1'b0;
    total++; if (in_ready !== 1'b0 || stall_cnt !== 16'd21) begin bad++; $display("FAIL rmid_setup got=%b/%0d exp=0/21", in_ready, stall_cnt); end
    #3 rst = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || out_ctrl !== 8'h00) begin bad++; $display("FAIL rmid_out got=%b/%h exp=0/00", out_valid, out_ctrl); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rmid_in_ready got=%b exp=1", in_ready); end
    total++; if (stall_cnt !== 16'd0 || bubble_cnt !== 16'd0 || s_stall_cnt !== 4'd0) begin bad++; $display("FAIL rmid_counters got=%0d/%0d/%0d exp=0/0/0", stall_cnt, bubble_cnt, s_stall_cnt); end
    step();
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_bubble();
    test_saturation();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage.md
# pipe_stage

Parametrised, elastic pipeline stage register that generalises the fixed IF/ID, ID/EX and EX/MEM registers of the RISC pipeline. It moves a control field and a payload field from one stage to the next through a valid/ready handshake. A two-entry skid buffer gives full throughput with no combinational ready path. It also provides synchronous flush with bubble insertion (control forced to zero) and saturating stall and bubble counters for performance debug. It is instantiated between every pair of pipeline stages.

## Interface
- DATA_W, 64, payload width (PC, operands, immediate, rd/rs fields packed by the instantiating stage)
- CTRL_W, 8, control-bit width (RegWrite, MemRead, MemWrite, MemtoReg, AluSrc, AluOp …); zeroed for bubbles
- CNT_W, 16, width of each performance counter
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream has a valid instruction
- in_ready  out  1  stage can accept; in_ready = !skid_valid (registered state only)
- in_ctrl  in  CTRL_W  upstream control bits
- in_data  in  DATA_W  upstream payload
- out_valid  out  1  main entry holds a valid instruction
- out_ready  in  1  downstream accepts
- out_ctrl  out  CTRL_W  main control; all zeros whenever out_valid=0
- out_data  out  DATA_W  main payload; value is don't-care when out_valid=0, but it holds its last value
- flush  in  1  synchronous kill of all held instructions (branch taken or hazard unit)
- stall_cnt  out  CNT_W  cycles with out_valid && !out_ready
- bubble_cnt  out  CNT_W  cycles with !out_valid && out_ready

## Operation
- push = in_valid && in_ready; pop = out_valid && out_ready.
- Internal state: main entry (main_valid, main_ctrl, main_data) and skid entry (skid_valid, skid_ctrl, skid_data).
- FSM states are decoded from the two valid bits:
  - EMPTY: main=0, skid=0
  - FULL: main=1, skid=0
  - SKID: main=1, skid=1
  - main=0 with skid=1 is illegal and must never occur.
- EMPTY: push → FULL, main←in.
- FULL, by case:
  - push && pop → FULL, main←in
  - push && !pop → SKID, skid←in
  - !push && pop → EMPTY
  - neither → hold
- SKID: in_ready=0, so no push can occur. pop → FULL with main←skid and skid cleared; otherwise hold.
- flush=1 → EMPTY on the next edge, with both ctrl registers cleared.
  - flush has priority over push: input offered in the flush cycle is discarded, although in_ready still reflects the pre-flush state.
  - A pop in the flush cycle is a completed transfer, because downstream already sampled it.
- Ordering is strictly FIFO; no entry is ever duplicated or dropped except by flush.
- Counters:
  - Each counter is incremented independently, once per cycle, when its condition holds.
  - Each saturates at 2^CNT_W−1 and never wraps.
  - flush does not clear the counters; only rst does.
- Data registers carry no reset requirement beyond the values listed below.

## Timing
- Reset (rst=0, asynchronous): main_valid=0, skid_valid=0, out_valid=0, out_ctrl=0, out_data=0, in_ready=1, stall_cnt=0, bubble_cnt=0.
- While rst=0, inputs are ignored. The first push can occur at the first rising edge after rst deasserts.
- Latency is 1 cycle: data pushed at edge N appears on out_* after edge N.
- Throughput is 1 transfer/cycle in steady state when out_ready=1.
- No combinational path exists from in_* to out_*, or from out_ready to in_ready. All outputs come directly from registers.
- in_ready drops in the cycle after the skid entry fills and rises in the cycle after a pop from SKID.
- After a flush at edge N: out_valid=0 and out_ctrl=0 from edge N on; in_ready=1.
- A simultaneous flush and out_ready=0 in SKID still empties both entries.

## Test plan
- Reset mid-operation: fill to SKID with out_ready=0, assert rst=0 asynchronously between edges → immediately out_valid=0, out_ctrl=0, in_ready=1, both counters=0.
- Streaming: out_ready=1, push data 0x10,0x20,0x30 on consecutive edges → out_data 0x10,0x20,0x30 one cycle later each; bubble_cnt unchanged during the burst.
- Backpressure: push A, B with out_ready=0 → after B, in_ready=0 and out_data=A. Raise out_ready for 2 cycles → outputs A then B, in_ready=1 after the first pop. stall_cnt increments by the number of stalled cycles.
- Flush: state SKID with ctrl=0xFF; assert flush together with in_valid=1 and data 0x99 → next cycle out_valid=0, out_ctrl=0x00, 0x99 never appears, in_ready=1.
- Bubble insertion: in_valid=0, out_ready=1 for 5 cycles from EMPTY → out_ctrl=0 throughout; bubble_cnt=5.
- Saturation with CNT_W=4: hold a stall for 20 cycles → stall_cnt stops at 15 and stays there.
